// File: rtl/sll_64bit_pkg.sv
// Shared widths and types for the 64-bit logical left shifter.
// Optional mid-pipeline cut is enabled by defining SLL_64BIT_PIPE_EN.
package sll_64bit_pkg;

    localparam int DATA_W  = 64;
    localparam int SHAMT_W = $clog2(DATA_W);

    // Index of the first stage that sits after the optional pipeline cut.
    localparam int PIPE_CUT = 3;

    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [SHAMT_W-1:0] shamt_t;

endpackage

// File: rtl/sll_64bit_stage.sv
// One barrel-shifter stage: shifts left by 2^K with zero fill when i_sel is set.
module sll_stage
    import sll_64bit_pkg::*;
#(
    parameter int K = 0
) (
    input  logic  i_sel,
    input  data_t i_data,
    output data_t o_data
);

    localparam int AMT = 1 << K;

    assign o_data = i_sel ? {i_data[DATA_W-1-AMT:0], {AMT{1'b0}}} : i_data;

endmodule

// File: rtl/sll_64bit.sv
// 64-bit logical left shifter: six log stages, optional output register (OUT_REG)
// and optional pipeline cut after the shift-by-4 stage (SLL_64BIT_PIPE_EN).
module sll_64bit
    import sll_64bit_pkg::*;
#(
    parameter bit OUT_REG = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              init_i,
    input  logic [SHAMT_W-1:0] shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              done_o,
    output logic [DATA_W-1:0] data_o
);

    data_t                        w_stage [0:SHAMT_W];
    data_t                        w_mid_data;
    logic [SHAMT_W-PIPE_CUT-1:0]  w_hi_sel;
    logic                         w_mid_vld;

    assign w_stage[0] = data_i;

`ifdef SLL_64BIT_PIPE_EN
    data_t                        r_pipe_data;
    logic [SHAMT_W-PIPE_CUT-1:0]  r_pipe_hi_sel;
    logic                         r_pipe_vld;

    // Data and remaining shift bits only advance on a valid operand; valid follows init_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pipe_data   <= '0;
            r_pipe_hi_sel <= '0;
            r_pipe_vld    <= 1'b0;
        end else begin
            r_pipe_vld <= init_i;
            if (init_i) begin
                r_pipe_data   <= w_stage[PIPE_CUT];
                r_pipe_hi_sel <= shift_i[SHAMT_W-1:PIPE_CUT];
            end
        end
    end

    assign w_mid_data = r_pipe_data;
    assign w_hi_sel   = r_pipe_hi_sel;
    assign w_mid_vld  = r_pipe_vld;
`else
    assign w_mid_data = w_stage[PIPE_CUT];
    assign w_hi_sel   = shift_i[SHAMT_W-1:PIPE_CUT];
    assign w_mid_vld  = init_i;
`endif

    genvar k;
    generate
        for (k = 0; k < SHAMT_W; k++) begin : g_stage
            data_t w_in;
            logic  w_sel;

            if (k == PIPE_CUT) begin : g_cut
                assign w_in = w_mid_data;
            end else begin : g_chain
                assign w_in = w_stage[k];
            end

            if (k < PIPE_CUT) begin : g_lo_sel
                assign w_sel = shift_i[k];
            end else begin : g_hi_sel
                assign w_sel = w_hi_sel[k-PIPE_CUT];
            end

            sll_stage #(.K(k)) u_stage (
                .i_sel  (w_sel),
                .i_data (w_in),
                .o_data (w_stage[k+1])
            );
        end

        if (OUT_REG) begin : g_out_reg
            data_t r_data;
            logic  r_done;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_data <= '0;
                    r_done <= 1'b0;
                end else begin
                    r_done <= w_mid_vld;
                    if (w_mid_vld) begin
                        r_data <= w_stage[SHAMT_W];
                    end
                end
            end

            assign data_o = r_data;
            assign done_o = r_done;
        end else begin : g_out_comb
            assign data_o = w_stage[SHAMT_W];
            assign done_o = w_mid_vld;
        end
    endgenerate

endmodule

// File: tb/tb_sll_64bit.sv
// Directed-vector bench for sll_64bit; checks registered and combinational builds side by side.
module tb_sll_64bit;

`ifdef SLL_64BIT_PIPE_EN
    localparam int L1 = 2;
    localparam int L0 = 1;
`else
    localparam int L1 = 1;
    localparam int L0 = 0;
`endif

    typedef struct {
        logic        init;
        logic [5:0]  sh;
        logic [63:0] d;
        logic [63:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init;
    logic [5:0]  sh;
    logic [63:0] din;
    logic        done_r, done_c;
    logic [63:0] dout_r, dout_c;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    sll_64bit #(.OUT_REG(1'b1)) dut_r (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .init_i  (init),
        .shift_i (sh),
        .data_i  (din),
        .done_o  (done_r),
        .data_o  (dout_r)
    );

    sll_64bit #(.OUT_REG(1'b0)) dut_c (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .init_i  (init),
        .shift_i (sh),
        .data_i  (din),
        .done_o  (done_c),
        .data_o  (dout_c)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic i, input logic [5:0] s, input logic [63:0] d, input logic [63:0] e);
        vec_t v;
        v.init = i; v.sh = s; v.d = d; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] m_rd, m_cd;
        logic        m_rdone, m_cdone;
        int          idx;

        // Hand-computed vectors, including a bubble that must not disturb the registered result.
        add(1'b1, 6'd0,  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        add(1'b1, 6'd4,  64'h0123_4567_89AB_CDEF, 64'h1234_5678_9ABC_DEF0);
        add(1'b1, 6'd8,  64'h0123_4567_89AB_CDEF, 64'h2345_6789_ABCD_EF00);
        add(1'b1, 6'd36, 64'h0123_4567_89AB_CDEF, 64'h9ABC_DEF0_0000_0000);
        add(1'b0, 6'd16, 64'hDEAD_BEEF_CAFE_BABE, 64'hBEEF_CAFE_BABE_0000);
        add(1'b1, 6'd16, 64'hDEAD_BEEF_CAFE_BABE, 64'hBEEF_CAFE_BABE_0000);
        add(1'b1, 6'd63, 64'h0000_0000_0000_0003, 64'h8000_0000_0000_0000);
        add(1'b1, 6'd1,  64'h8000_0000_0000_0001, 64'h0000_0000_0000_0002);
        for (int i = 0; i < 64; i++)
            add(1'b1, 6'(i), 64'hFFFF_FFFF_FFFF_FFFF, ~((64'h1 << i) - 64'h1));
        for (int i = 0; i < 64; i++)
            add(1'b1, 6'(i), 64'h1, 64'h1 << i);
        add(1'b0, 6'd4, 64'hFFFF_0000_FFFF_0000, 64'hFFF0_000F_FFF0_0000);
        for (int i = 0; i < 3; i++)
            add(1'b0, 6'd0, 64'h0, 64'h0);

        // Reset with all-ones operand presented.
        rst_n = 1'b0; init = 1'b1; sh = 6'd0; din = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("rst_data", dout_r, 64'h0);
        chk("rst_done", {63'b0, done_r}, 64'h0);
        #1;
        rst_n = 1'b1; init = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_data", dout_r, 64'h0);
            chk("post_rst_done", {63'b0, done_r}, 64'h0);
        end

        m_rd = 64'h0; m_rdone = 1'b0;
        m_cd = 64'h0; m_cdone = 1'b0;
        for (int c = 0; c < vecs.size(); c++) begin
            @(posedge clk);
            #1;
            init = vecs[c].init; sh = vecs[c].sh; din = vecs[c].d;
            @(negedge clk);

            idx = c - L1;
            m_rdone = 1'b0;
            if (idx >= 0) begin
                m_rdone = vecs[idx].init;
                if (vecs[idx].init) m_rd = vecs[idx].exp;
            end
            chk("reg_data", dout_r, m_rd);
            chk("reg_done", {63'b0, done_r}, {63'b0, m_rdone});

            if (L0 == 0) begin
                m_cd    = vecs[c].exp;
                m_cdone = vecs[c].init;
            end else begin
                idx = c - L0;
                m_cdone = 1'b0;
                if (idx >= 0) begin
                    m_cdone = vecs[idx].init;
                    if (vecs[idx].init) m_cd = vecs[idx].exp;
                end
            end
            chk("comb_data", dout_c, m_cd);
            chk("comb_done", {63'b0, done_c}, {63'b0, m_cdone});
        end

        // After the strobe drop the last walking-one result must still be held.
        chk("hold_data", dout_r, 64'h8000_0000_0000_0000);

        // Mid-stream reset: clears asynchronously and aborts anything in flight.
        @(posedge clk);
        #1;
        init = 1'b1; sh = 6'd4; din = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (L1) @(posedge clk);
        #1;
        chk("mid_data", dout_r, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("mid_done", {63'b0, done_r}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_data", dout_r, 64'h0);
        chk("async_done", {63'b0, done_r}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1; init = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_data", dout_r, 64'h0);
            chk("abort_done", {63'b0, done_r}, 64'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
